// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and header tag.
// Ports: none (package uart_arb_pkg, imported by the arbiter top).
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [3:0] HDR_TAG = 4'hA;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle for uart_tx_arbiter.
// Ports: req_valid/req_data/req_last/req_ready per requester, wr_uart/data_in/tx_full to the
// transmitter, busy/grant_id status. slave = arbiter side, master = sources and transmitter.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               wr_uart;
    logic [7:0]         data_in;
    logic               tx_full;
    logic               busy;
    logic [IDW-1:0]     grant_id;

    modport master (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, wr_uart, data_in, busy, grant_id
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, wr_uart, data_in, busy, grant_id
    );
endinterface

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first valid index at or after rr_ptr, wrapping mod N_REQ.
// Ports: req_valid[N_REQ], rr_ptr[IDW] in; any_valid, pick_id[IDW] out.
module uart_rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDW-1:0]   rr_ptr,
    output logic             any_valid,
    output logic [IDW-1:0]   pick_id
);

    // Scan from the farthest candidate back to rr_ptr so the nearest valid one wins.
    always_comb begin
        any_valid = 1'b0;
        pick_id   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                any_valid = 1'b1;
                pick_id   = IDW'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-granting arbiter sharing one UART transmitter among N_REQ byte sources.
// Ports: clk, reset (async, active-high), bus (uart_tx_arbiter_if.slave).
// Build option: UART_ARB_HDR_EN adds one header byte {HDR_TAG, grant_id} per grant.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16,
    parameter int IDW       = 2
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);

    state_e         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_id;
    logic [7:0]     byte_cnt;
    logic [7:0]     data_in;
    logic           busy;
    logic           wr_uart;

    logic           any_valid;
    logic [IDW-1:0] pick_id;

    uart_rr_picker #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_picker (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .any_valid (any_valid),
        .pick_id   (pick_id)
    );

    // A write slot exists only when the transmitter has room and no strobe is
    // already in flight, which caps throughput at one byte every two cycles.
    logic can_wr;
    assign can_wr = ~bus.tx_full & ~wr_uart;

    logic [N_REQ-1:0] ready;
    always_comb begin
        ready = '0;
        if (state == ST_DATA && can_wr) begin
            ready[grant_id] = 1'b1;
        end
    end

    logic       accept;
    logic       burst_end;
    logic [7:0] cur_byte;
    logic [IDW-1:0] next_ptr;

    assign accept    = (state == ST_DATA) & can_wr & bus.req_valid[grant_id];
    assign cur_byte  = bus.req_data[int'(grant_id)*8 +: 8];
    assign burst_end = bus.req_last[grant_id] | (byte_cnt == 8'(MAX_BURST - 1));
    assign next_ptr  = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            byte_cnt <= '0;
            data_in  <= 8'h00;
            busy     <= 1'b0;
            wr_uart  <= 1'b0;
        end else begin
            wr_uart <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        grant_id <= pick_id;
                        busy     <= 1'b1;
`ifdef UART_ARB_HDR_EN
                        state    <= ST_HDR;
`else
                        state    <= ST_DATA;
`endif
                    end
                end
`ifdef UART_ARB_HDR_EN
                ST_HDR: begin
                    if (can_wr) begin
                        wr_uart <= 1'b1;
                        data_in <= {HDR_TAG, 4'(grant_id)};
                        state   <= ST_DATA;
                    end
                end
`endif
                ST_DATA: begin
                    if (accept) begin
                        wr_uart <= 1'b1;
                        data_in <= cur_byte;
                        if (burst_end) begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            byte_cnt <= '0;
                            rr_ptr   <= next_ptr;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.wr_uart   = wr_uart;
    assign bus.data_in   = data_in;
    assign bus.busy      = busy;
    assign bus.grant_id  = grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a transaction-level reference model.
// Covers single bursts, round-robin order, burst cap, tx_full stall, mid-burst reset, header option.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int MB  = 16;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    uart_tx_arbiter_if #(.N_REQ(N), .IDW(IDW)) bus ();

    uart_tx_arbiter #(
        .N_REQ     (N),
        .MAX_BURST (MB),
        .IDW       (IDW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source queues: {last, data} per requester.
    logic [8:0] rq [N][$];
    int  gap_pct = 0;
    int  full_mode = 0;
    bit  in_reset = 1'b1;

    // Reference model state.
    int  m_ptr = 0;
    int  m_owner = 0;
    int  m_cnt = 0;
    bit  m_busy = 1'b0;
    bit  m_hdr_pend = 1'b0;
    bit  acc_prev = 1'b0;
    bit  full_prev = 1'b0;
    logic [7:0] expq[$];
    logic [7:0] wlog[$];
    logic [7:0] exp_w[$];
    int  glog[$];
    int  blen[$];

    function automatic int pick(logic [N-1:0] v, int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() != 0) return 1'b1;
        end
        return (expq.size() != 0) || m_hdr_pend;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        logic [N-1:0] acc;
        logic [8:0]   head;
        int           w;
        if (in_reset) begin
            bus.req_valid = '0;
            bus.req_last  = '0;
            bus.req_data  = '0;
            bus.tx_full   = 1'b0;
            acc_prev      = 1'b0;
            full_prev     = 1'b0;
        end else begin
            check("busy", bus.busy, m_busy);
            check("grant_id", bus.grant_id, m_owner);
            if (acc_prev) check("wr_latency", bus.wr_uart, 1);
            if (full_prev) check("wr_while_full", bus.wr_uart, 0);
            if (bus.wr_uart) begin
                wlog.push_back(bus.data_in);
                if (m_hdr_pend) begin
                    check("hdr_byte", bus.data_in, {4'hA, 4'(m_owner)});
                    m_hdr_pend = 1'b0;
                end else if (expq.size() == 0) begin
                    check("spurious_wr", bus.wr_uart, 0);
                end else begin
                    check("wr_data", bus.data_in, expq.pop_front());
                end
            end
            for (int i = 0; i < N; i++) begin
                bit v;
                v = (rq[i].size() != 0) && ($urandom_range(99) >= gap_pct);
                bus.req_valid[i] = v;
                if (v) begin
                    bus.req_data[8*i +: 8] = rq[i][0][7:0];
                    bus.req_last[i]        = rq[i][0][8];
                end else begin
                    bus.req_data[8*i +: 8] = 8'($urandom);
                    bus.req_last[i]        = 1'($urandom);
                end
            end
            case (full_mode)
                1:       bus.tx_full = ($urandom_range(99) < 30);
                2:       bus.tx_full = 1'b1;
                default: bus.tx_full = 1'b0;
            endcase
            #1;
            exp_rdy = '0;
            if (m_busy && !m_hdr_pend && !bus.tx_full && !bus.wr_uart)
                exp_rdy[m_owner] = 1'b1;
            check("req_ready", bus.req_ready, exp_rdy);
            acc = bus.req_valid & bus.req_ready;
            acc_prev = 1'b0;
            if (!m_busy) begin
                w = pick(bus.req_valid, m_ptr);
                if (w >= 0) begin
                    m_busy  = 1'b1;
                    m_owner = w;
                    m_cnt   = 0;
                    glog.push_back(w);
`ifdef UART_ARB_HDR_EN
                    m_hdr_pend = 1'b1;
`endif
                end
            end else if (acc != '0 && rq[m_owner].size() != 0) begin
                head = rq[m_owner].pop_front();
                expq.push_back(head[7:0]);
                m_cnt++;
                acc_prev = 1'b1;
                if (head[8] || m_cnt == MB) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % N;
                    blen.push_back(m_cnt);
                end
            end
            full_prev = bus.tx_full;
        end
    end

    task automatic load(int r, int n, logic [7:0] base, bit with_last);
        for (int i = 0; i < n; i++) begin
            rq[r].push_back({with_last && (i == n - 1), base + 8'(i)});
        end
    endtask

    task automatic exp_hdr(int r);
`ifdef UART_ARB_HDR_EN
        exp_w.push_back({4'hA, 4'(r)});
`else
        if (r < 0) exp_w.push_back(8'h00);
`endif
    endtask

    task automatic exp_bytes(int n, logic [7:0] base);
        for (int i = 0; i < n; i++) exp_w.push_back(base + 8'(i));
    endtask

    task automatic clear_logs();
        wlog.delete();
        exp_w.delete();
        glog.delete();
        blen.delete();
    endtask

    task automatic drain(string tag, int budget);
        int k;
        k = 0;
        while (pending() && k < budget) begin
            @(posedge clk);
            k++;
        end
        check(tag, (k < budget), 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_cnt(string tag, int n, int budget);
        int k;
        k = 0;
        while (!(m_busy && m_cnt >= n) && k < budget) begin
            @(posedge clk);
            k++;
        end
        check(tag, (k < budget), 1);
    endtask

    task automatic cmp_log(string tag);
        check({tag, "_nwr"}, wlog.size(), exp_w.size());
        for (int i = 0; i < wlog.size() && i < exp_w.size(); i++) begin
            check({tag, "_wr"}, wlog[i], exp_w[i]);
        end
    endtask

    task automatic do_reset_model();
        for (int i = 0; i < N; i++) rq[i].delete();
        expq.delete();
        m_ptr = 0;
        m_owner = 0;
        m_cnt = 0;
        m_busy = 1'b0;
        m_hdr_pend = 1'b0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.tx_full   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.req_ready, 0);
        check("rst_wr", bus.wr_uart, 0);
        check("rst_data", bus.data_in, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_gid", bus.grant_id, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        in_reset = 1'b0;

        // 1: single 3-byte burst from req0
        clear_logs();
        rq[0].push_back({1'b0, 8'h54});
        rq[0].push_back({1'b0, 8'h41});
        rq[0].push_back({1'b1, 8'h42});
        exp_hdr(0);
        exp_w.push_back(8'h54);
        exp_w.push_back(8'h41);
        exp_w.push_back(8'h42);
        drain("t1_drain", 200);
        cmp_log("t1");
        @(negedge clk);
        #2;
        check("t1_busy", bus.busy, 0);
        check("t1_rr_ptr", dut.rr_ptr, 1);

        // 2: req1 and req3 together with rr_ptr=2
        load(1, 1, 8'h10, 1'b1);
        drain("t2_pre", 200);
        clear_logs();
        load(1, 2, 8'h20, 1'b1);
        load(3, 2, 8'h30, 1'b1);
        exp_hdr(3);
        exp_bytes(2, 8'h30);
        exp_hdr(1);
        exp_bytes(2, 8'h20);
        drain("t2_drain", 300);
        check("t2_ngrant", glog.size(), 2);
        if (glog.size() == 2) begin
            check("t2_g0", glog[0], 3);
            check("t2_g1", glog[1], 1);
        end
        cmp_log("t2");

        // 3: 20 bytes with no last from req2
        clear_logs();
        load(2, 20, 8'h60, 1'b0);
        exp_hdr(2);
        exp_bytes(16, 8'h60);
        exp_hdr(2);
        exp_bytes(4, 8'h70);
        drain("t3_drain", 500);
        cmp_log("t3");
        check("t3_ngrant", glog.size(), 2);
        if (glog.size() == 2) begin
            check("t3_g0", glog[0], 2);
            check("t3_g1", glog[1], 2);
        end
        check("t3_nburst", blen.size(), 1);
        if (blen.size() != 0) check("t3_len0", blen[0], MB);
        load(2, 1, 8'h7F, 1'b1);
        drain("t3_close", 100);

        // 4: tx_full held 50 cycles mid-burst
        clear_logs();
        load(0, 10, 8'h80, 1'b1);
        exp_hdr(0);
        exp_bytes(10, 8'h80);
        wait_cnt("t4_start", 3, 200);
        full_mode = 2;
        repeat (50) @(posedge clk);
        full_mode = 0;
        drain("t4_drain", 300);
        cmp_log("t4");

        // 5: reset after 2 of 5 bytes
        load(1, 5, 8'h90, 1'b1);
        wait_cnt("t5_start", 2, 200);
        @(posedge clk);
        #2;
        reset = 1'b1;
        in_reset = 1'b1;
        #1;
        check("t5_ready", bus.req_ready, 0);
        check("t5_wr", bus.wr_uart, 0);
        check("t5_data", bus.data_in, 0);
        check("t5_busy", bus.busy, 0);
        check("t5_gid", bus.grant_id, 0);
        check("t5_ptr", dut.rr_ptr, 0);
        do_reset_model();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        in_reset = 1'b0;
        @(negedge clk);
        #2;
        check("t5_wr_after", bus.wr_uart, 0);
        clear_logs();
        load(0, 1, 8'hB0, 1'b1);
        load(3, 1, 8'hB3, 1'b1);
        drain("t5_drain", 200);
        check("t5_ngrant", glog.size(), 2);
        if (glog.size() != 0) check("t5_g0", glog[0], 0);

        // 6: single byte 8'hDF from req1
        clear_logs();
        load(1, 1, 8'hDF, 1'b1);
        exp_hdr(1);
        exp_w.push_back(8'hDF);
        drain("t6_drain", 100);
        cmp_log("t6");

        // random traffic with gaps and tx_full noise
        gap_pct = 30;
        full_mode = 1;
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < N; r++) begin
                if ($urandom_range(1) == 1)
                    load(r, $urandom_range(20, 1), 8'($urandom), 1'b1);
            end
            drain("rnd_drain", 3000);
        end
        full_mode = 0;
        gap_pct = 0;
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
